// File: rtl/dec_ib_fifo_wr.sv
// rtl/dec_ib_fifo_wr.sv - decode-side instruction queue fed by the fetch aligner
//
// Purpose: circular store of aligned instructions; accepts up to two per cycle,
// retires up to two per cycle, and presents the oldest two entries show-ahead.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   exu_flush_final               empties the queue (beats same-cycle read/write)
//   ifu_i{0,1}_*                  aligner instruction valid/instr/cinst/pc_pkt/brp
//   ifu_dbg_wdata_rs1/_fence      debug flags, kept with the i0 entry only
//   dec_i{0,1}_decode_d           decode consumed head / head+1
//   ifu_ib_ready                  at least two free entries (registered count only)
//   dec_ib{0..3}_valid_d_fifo     occupancy > 0 .. > 3
//   dec_i{0,1}_*_fifo, pc{0,1}_fifo  head / head+1 entry contents
//   dec_debug_*_d_fifo            head entry debug flags
//   fifo_count                    occupancy 0..DEPTH
//   fifo_overflow                 sticky; a write was dropped for lack of space

package dec_ib_pkg;
  typedef struct packed {
    logic        valid;
    logic [11:0] toffset;
    logic [1:0]  hist;
    logic        br_error;
    logic        br_start_error;
    logic        bank;
    logic [31:1] prett;
    logic        way;
    logic        ret;
  } br_pkt_t;
endpackage

module dec_ib_fifo_wr
  import dec_ib_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          exu_flush_final,
  input  logic          ifu_i0_valid,
  input  logic          ifu_i1_valid,
  input  logic [31:0]   ifu_i0_instr,
  input  logic [31:0]   ifu_i1_instr,
  input  logic [15:0]   ifu_i0_cinst,
  input  logic [15:0]   ifu_i1_cinst,
  input  logic [36:0]   ifu_i0_pc_pkt,
  input  logic [36:0]   ifu_i1_pc_pkt,
  input  br_pkt_t       ifu_i0_brp,
  input  br_pkt_t       ifu_i1_brp,
  input  logic          ifu_dbg_wdata_rs1,
  input  logic          ifu_dbg_fence,
  input  logic          dec_i0_decode_d,
  input  logic          dec_i1_decode_d,
  output logic          ifu_ib_ready,
  output logic          dec_ib0_valid_d_fifo,
  output logic          dec_ib1_valid_d_fifo,
  output logic          dec_ib2_valid_d_fifo,
  output logic          dec_ib3_valid_d_fifo,
  output logic [31:0]   dec_i0_instr_d_fifo,
  output logic [31:0]   dec_i1_instr_d_fifo,
  output logic [15:0]   dec_i0_cinst_d_fifo,
  output logic [15:0]   dec_i1_cinst_d_fifo,
  output logic [36:0]   pc0_fifo,
  output logic [36:0]   pc1_fifo,
  output br_pkt_t       dec_i0_brp_fifo,
  output br_pkt_t       dec_i1_brp_fifo,
  output logic          dec_debug_wdata_rs1_d_fifo,
  output logic          dec_debug_fence_d_fifo,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] cinst;
    logic [36:0] pc_pkt;
    br_pkt_t     brp;
    logic        dbg_wdata_rs1;
    logic        dbg_fence;
  } ib_entry_t;

  ib_entry_t     mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          overflow_q;

  logic [1:0]    wr_n;
  logic [1:0]    rd_raw;
  logic [1:0]    rd_n;
  logic [1:0]    wr_cnt;
  logic          wr_ok;
  logic [CW1-1:0] room;
  ib_entry_t     wr_e0;
  ib_entry_t     wr_e1;
  logic [AW-1:0] wp1;
  logic [AW-1:0] rp1;
  ib_entry_t     head0;
  ib_entry_t     head1;

  // A lone i1 valid / lone i1 decode carries no meaning and is ignored.
  assign wr_n   = {1'b0, ifu_i0_valid} + {1'b0, ifu_i0_valid & ifu_i1_valid};
  assign rd_raw = {1'b0, dec_i0_decode_d} + {1'b0, dec_i0_decode_d & dec_i1_decode_d};

  // Reads never retire more than is present; with count < 2 the low bits are exact.
  always_comb begin
    rd_n = rd_raw;
    if (count < CW'(rd_raw)) rd_n = count[1:0];
  end

  // Same-cycle reads free space for writes, so a full queue can take 2-in/2-out.
  assign room   = CW1'(DEPTH) - {1'b0, count} + CW1'(rd_n);
  assign wr_ok  = CW1'(wr_n) <= room;
  assign wr_cnt = (wr_ok && !exu_flush_final) ? wr_n : 2'd0;

  assign wp1 = wp + AW'(1);
  assign rp1 = rp + AW'(1);

  assign wr_e0 = '{instr: ifu_i0_instr, cinst: ifu_i0_cinst, pc_pkt: ifu_i0_pc_pkt,
                   brp: ifu_i0_brp, dbg_wdata_rs1: ifu_dbg_wdata_rs1,
                   dbg_fence: ifu_dbg_fence};
  assign wr_e1 = '{instr: ifu_i1_instr, cinst: ifu_i1_cinst, pc_pkt: ifu_i1_pc_pkt,
                   brp: ifu_i1_brp, dbg_wdata_rs1: 1'b0, dbg_fence: 1'b0};

  // Storage is cleared on reset so unused output data reads as 0, never X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_cnt != 2'd0) mem[wp]  <= wr_e0;
      if (wr_cnt == 2'd2) mem[wp1] <= wr_e1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (exu_flush_final) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      rp    <= rp + AW'(rd_n);
      wp    <= wp + AW'(wr_cnt);
      count <= count + CW'(wr_cnt) - CW'(rd_n);
    end
  end

  // Sticky until reset; a flushed write is discarded, not counted as dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (!exu_flush_final && (wr_n != 2'd0) && !wr_ok) begin
      overflow_q <= 1'b1;
    end
  end

  assign head0 = mem[rp];
  assign head1 = mem[rp1];

  assign dec_ib0_valid_d_fifo = count > CW'(0);
  assign dec_ib1_valid_d_fifo = count > CW'(1);
  assign dec_ib2_valid_d_fifo = count > CW'(2);
  assign dec_ib3_valid_d_fifo = count > CW'(3);

  assign ifu_ib_ready = (CW'(DEPTH) - count) >= CW'(2);

  assign dec_i0_instr_d_fifo        = head0.instr;
  assign dec_i1_instr_d_fifo        = head1.instr;
  assign dec_i0_cinst_d_fifo        = head0.cinst;
  assign dec_i1_cinst_d_fifo        = head1.cinst;
  assign pc0_fifo                   = head0.pc_pkt;
  assign pc1_fifo                   = head1.pc_pkt;
  assign dec_i0_brp_fifo            = head0.brp;
  assign dec_i1_brp_fifo            = head1.brp;
  assign dec_debug_wdata_rs1_d_fifo = head0.dbg_wdata_rs1;
  assign dec_debug_fence_d_fifo     = head0.dbg_fence;

  assign fifo_count    = count;
  assign fifo_overflow = overflow_q;

endmodule

// File: tb/tb_dec_ib_fifo_wr.sv
// tb/tb_dec_ib_fifo_wr.sv - self-checking bench for dec_ib_fifo_wr
module tb_dec_ib_fifo_wr;
  import dec_ib_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [15:0] cinst;
    logic [36:0] pc;
    br_pkt_t     brp;
    logic        dw;
    logic        df;
  } te_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fl = 1'b0, v0 = 1'b0, v1 = 1'b0, d0 = 1'b0, d1 = 1'b0;
  te_t  in0 = '0, in1 = '0;

  logic          ready, ib0, ib1, ib2, ib3;
  logic [31:0]   instr0, instr1;
  logic [15:0]   cinst0, cinst1;
  logic [36:0]   pc0, pc1;
  br_pkt_t       brp0, brp1;
  logic          dbgw, dbgf;
  logic [CW-1:0] cnt;
  logic          ovf;

  dec_ib_fifo_wr #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .exu_flush_final(fl),
    .ifu_i0_valid(v0), .ifu_i1_valid(v1),
    .ifu_i0_instr(in0.instr), .ifu_i1_instr(in1.instr),
    .ifu_i0_cinst(in0.cinst), .ifu_i1_cinst(in1.cinst),
    .ifu_i0_pc_pkt(in0.pc), .ifu_i1_pc_pkt(in1.pc),
    .ifu_i0_brp(in0.brp), .ifu_i1_brp(in1.brp),
    .ifu_dbg_wdata_rs1(in0.dw), .ifu_dbg_fence(in0.df),
    .dec_i0_decode_d(d0), .dec_i1_decode_d(d1),
    .ifu_ib_ready(ready),
    .dec_ib0_valid_d_fifo(ib0), .dec_ib1_valid_d_fifo(ib1),
    .dec_ib2_valid_d_fifo(ib2), .dec_ib3_valid_d_fifo(ib3),
    .dec_i0_instr_d_fifo(instr0), .dec_i1_instr_d_fifo(instr1),
    .dec_i0_cinst_d_fifo(cinst0), .dec_i1_cinst_d_fifo(cinst1),
    .pc0_fifo(pc0), .pc1_fifo(pc1),
    .dec_i0_brp_fifo(brp0), .dec_i1_brp_fifo(brp1),
    .dec_debug_wdata_rs1_d_fifo(dbgw), .dec_debug_fence_d_fifo(dbgf),
    .fifo_count(cnt), .fifo_overflow(ovf)
  );

  always #5 clk = ~clk;

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 1'b0;
  te_t q[$];
  bit  m_ovf = 1'b0;
  int  sq = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic te_t gen(input int s);
    te_t e;
    e.instr = 32'h0000_0093 | (32'(s) << 20);
    e.cinst = 16'h4000 + 16'(s);
    e.pc    = {5'(s), 32'h0000_2000 + 32'(s * 4)};
    e.brp   = br_pkt_t'(51'(s) * 51'h1_2345);
    e.dw    = s[0];
    e.df    = s[1];
    return e;
  endfunction

  // Queue model: occupancy is the queue length; head is q[0].
  task automatic model_step();
    int  wrn, rdn;
    te_t e0, e1;
    wrn = v0 ? (v1 ? 2 : 1) : 0;
    rdn = d0 ? (d1 ? 2 : 1) : 0;
    if (rdn > q.size()) rdn = q.size();
    if (fl) begin
      q.delete();
    end else if (wrn <= DEPTH - q.size() + rdn) begin
      repeat (rdn) void'(q.pop_front());
      e0 = in0;
      e1 = in1;
      e1.dw = 1'b0;
      e1.df = 1'b0;
      if (wrn >= 1) q.push_back(e0);
      if (wrn == 2) q.push_back(e1);
    end else begin
      repeat (rdn) void'(q.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic go(input bit a0, a1, r0, r1, f, input te_t e0, e1);
    v0 = a0; v1 = a1; d0 = r0; d1 = r1; fl = f;
    in0 = e0; in1 = e1;
    @(posedge clk);
    model_step();
    #1;
    v0 = 1'b0; v1 = 1'b0; d0 = 1'b0; d1 = 1'b0; fl = 1'b0;
  endtask

  task automatic wr2();
    go(1, 1, 0, 0, 0, gen(sq), gen(sq + 1));
    sq += 2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("count", 64'(cnt), 64'(q.size()));
      chk("ready", 64'(ready), 64'((DEPTH - q.size()) >= 2));
      chk("ib0", 64'(ib0), 64'(q.size() > 0));
      chk("ib1", 64'(ib1), 64'(q.size() > 1));
      chk("ib2", 64'(ib2), 64'(q.size() > 2));
      chk("ib3", 64'(ib3), 64'(q.size() > 3));
      chk("overflow", 64'(ovf), 64'(m_ovf));
      if (q.size() > 0) begin
        chk("instr0", 64'(instr0), 64'(q[0].instr));
        chk("cinst0", 64'(cinst0), 64'(q[0].cinst));
        chk("pc0", 64'(pc0), 64'(q[0].pc));
        chk("brp0", 64'(brp0), 64'(q[0].brp));
        chk("dbg_w", 64'(dbgw), 64'(q[0].dw));
        chk("dbg_f", 64'(dbgf), 64'(q[0].df));
      end
      if (q.size() > 1) begin
        chk("instr1", 64'(instr1), 64'(q[1].instr));
        chk("cinst1", 64'(cinst1), 64'(q[1].cinst));
        chk("pc1", 64'(pc1), 64'(q[1].pc));
        chk("brp1", 64'(brp1), 64'(q[1].brp));
      end
    end
  end

  initial begin
    te_t a, b;
    int  c0, cn;

    // Reset state, then the first 2-write.
    do_reset();
    chk_en = 1'b1;
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_ib0", 64'(ib0), 64'd0);
    chk("rst_instr0", 64'(instr0), 64'd0);
    chk("rst_pc1", 64'(pc1), 64'd0);
    a = '0; a.instr = 32'h0000_0013; a.pc = 37'h0_0000_1001; a.cinst = 16'h0001; a.dw = 1'b1;
    b = '0; b.instr = 32'h0010_0093; b.pc = 37'h0_0000_1005; b.cinst = 16'h0002;
    go(1, 1, 0, 0, 0, a, b);
    chk("a_count", 64'(cnt), 64'd2);
    chk("a_ib0", 64'(ib0), 64'd1);
    chk("a_ib1", 64'(ib1), 64'd1);
    chk("a_ib2", 64'(ib2), 64'd0);
    chk("a_instr0", 64'(instr0), 64'h13);
    chk("a_pc0", 64'(pc0), 64'h0_0000_1001);
    chk("a_instr1", 64'(instr1), 64'h0010_0093);
    chk("a_dbgw", 64'(dbgw), 64'd1);
    // Lone i1 valid and lone i1 decode are ignored.
    go(0, 1, 0, 1, 0, gen(90), gen(91));
    chk("lone_i1_count", 64'(cnt), 64'd2);

    // Fill to full, then overflow.
    do_reset();
    repeat (4) wr2();
    chk("full_count", 64'(cnt), 64'd8);
    chk("full_ib3", 64'(ib3), 64'd1);
    chk("full_ready", 64'(ready), 64'd0);
    chk("full_ovf", 64'(ovf), 64'd0);
    wr2();
    chk("ovf_count", 64'(cnt), 64'd8);
    chk("ovf_set", 64'(ovf), 64'd1);

    // Drain to 5, then flush with a 2-write.
    go(0, 0, 1, 1, 0, gen(0), gen(0));
    go(0, 0, 1, 0, 0, gen(0), gen(0));
    chk("pre_flush_count", 64'(cnt), 64'd5);
    wr2();
    chk("f_count_pre", 64'(cnt), 64'd7);
    go(1, 1, 0, 0, 1, gen(sq), gen(sq + 1));
    sq += 2;
    chk("flush_count", 64'(cnt), 64'd0);
    chk("flush_ib0", 64'(ib0), 64'd0);
    chk("flush_ready", 64'(ready), 64'd1);
    chk("flush_ovf_kept", 64'(ovf), 64'd1);

    // Full queue accepts 2-in/2-out.
    do_reset();
    chk("c_ovf_cleared", 64'(ovf), 64'd0);
    c0 = sq;
    repeat (4) wr2();
    cn = sq;
    go(1, 1, 1, 1, 0, gen(sq), gen(sq + 1));
    sq += 2;
    chk("rw_count", 64'(cnt), 64'd8);
    chk("rw_ovf", 64'(ovf), 64'd0);
    chk("rw_instr0", 64'(instr0), 64'(gen(c0 + 2).instr));
    chk("rw_instr1", 64'(instr1), 64'(gen(c0 + 3).instr));

    // Move rp to 7 and run 1-in/1-out across the wrap.
    go(0, 0, 1, 1, 0, gen(0), gen(0));
    go(0, 0, 1, 1, 0, gen(0), gen(0));
    go(0, 0, 1, 0, 0, gen(0), gen(0));
    chk("wrap_count", 64'(cnt), 64'd3);
    chk("wrap_pc0", 64'(pc0), 64'(gen(c0 + 7).pc));
    chk("wrap_pc1", 64'(pc1), 64'(gen(cn).pc));
    for (int i = 0; i < 10; i++) begin
      go(1, 0, 1, 0, 0, gen(sq), gen(0));
      sq++;
    end
    chk("wrap_end_count", 64'(cnt), 64'd3);
    chk("wrap_end_instr0", 64'(instr0), 64'(gen(sq - 3).instr));

    // Over-read clamps: count 1 with a 2-read.
    go(0, 0, 1, 1, 0, gen(0), gen(0));
    chk("e_count1", 64'(cnt), 64'd1);
    go(0, 0, 1, 1, 0, gen(0), gen(0));
    chk("e_count0", 64'(cnt), 64'd0);
    chk("e_ib0", 64'(ib0), 64'd0);
    go(0, 0, 1, 1, 0, gen(0), gen(0));
    chk("e_empty_read", 64'(cnt), 64'd0);
    go(1, 0, 0, 0, 0, gen(77), gen(0));
    chk("e_write_count", 64'(cnt), 64'd1);
    chk("e_write_instr0", 64'(instr0), 64'(gen(77).instr));
    go(0, 0, 0, 0, 0, gen(0), gen(0));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
